clock_divider_multi: RTL and testbench
======================================

// Module: clock_divider_multi
// PURPOSE
//  Parametrised N-channel clock divider: next generation of the fixed 4 Hz / divide-by-5 dividers.
//  Each channel has a runtime-programmable half-period, an enable and a one-cycle tick strobe.
//  Divisor updates are glitch-free.
//  Sits beside the system clock input and feeds slow timing (display scan, blink, debounce) to the datapath.
// PARAMETERS
//  CH       2           number of independent channels (1..16)
//  W        26          divisor/counter width in bits
//  DEF_DIV  12500000    reset half-period for every channel (4 Hz from 100 MHz); must fit in W
//  SELW     $clog2(CH)  select width (localparam; 1 when CH==1)
// PORTS
//  clk       in   1        system clock; all logic on posedge
//  CLEARn    in   1        asynchronous active-low reset
//  en        in   CH       per-channel run enable, level
//  cfg_we    in   1        divisor write strobe, one cycle
//  cfg_sel   in   SELW     channel index for the write
//  cfg_div   in   W        new half-period D (input cycles)
//  clk_out   out  CH       divided clocks, registered
//  tick      out  CH       one-clk pulse at every clk_out toggle, registered
// BEHAVIOUR
//  - Reset (CLEARn low, async): cnt=0, clk_out=0, tick=0, active div = shadow div = DEF_DIV, pend=0, all channels.
//  - Per channel, en=1, D=active div >= 1:
//    - cnt counts 0..D-1.
//    - On the cycle cnt==D-1: cnt<=0, clk_out toggles, tick<=1 for exactly one cycle.
//    - Output period = 2*D clk. Duty exactly 50%. D=1 gives clk/2 with tick high every cycle.
//  - First toggle after reset or enable: D cycles after the first en=1 edge, with clk_out rising.
//  - en=0: cnt<=0, clk_out<=0, tick<=0 on the next edge, held there. A pending divisor loads immediately.
//  - D=0: channel stopped, same as en=0; shadow can still be written.
//  - cfg_we=1 with cfg_sel<CH: shadow[sel]<=cfg_div, pend[sel]<=1. cfg_sel>=CH: write ignored, no state change.
//  - Shadow moves to active only at a terminal count (cnt==D-1), or while the channel is idle (en=0 or D=0).
//    Never mid-half-period, so no runt pulses.
//  - Write on the same cycle as a terminal count: cfg_div bypasses straight to active at that edge. Next half-period uses it.
//  - Back-to-back writes before a load: last write wins.
//  - cnt never exceeds W bits. Compare is unsigned. Counter wrap is impossible because the terminal-count compare is ==D-1.
//  - Channels are fully independent; simultaneous terminal counts on several channels are legal.
//  - Reset mid-operation: all state returns to the reset values asynchronously; no tick is emitted.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined:
//   - Adds input `sync_restart` (1 bit).
//   - While high on a clock edge, every channel does cnt<=0, clk_out<=0, tick<=0, and loads any pending shadow.
//   - Channels with equal D are phase-aligned afterwards. This takes priority over the terminal count.
//  CLKDIV_SYNC_EN undefined: port absent; channels align only via reset/enable.
// TESTING (bench overrides DEF_DIV=5, CH=2, W=8)
//  1 Release CLEARn, en=2'b11 -> clk_out[0] rises after 5 clk, period 10 clk, tick every 5 clk; both channels identical.
//  2 Write ch1 D=3 mid-half-period (cnt=2) -> current half-period stays 5.
//    Subsequent half-periods are 3 clk; no pulse shorter than 3.
//  3 Write ch0 D=2 on the exact terminal-count cycle -> next half-period is 2 clk.
//    Write cfg_sel=3 -> no channel changes.
//  4 en[0]=0 for 4 clk, then 1 -> clk_out[0]=0 and tick[0]=0 while low.
//    First rise 5 clk after re-enable; D=0 write also holds low.
//  5 D=1 on ch1 -> clk_out[1] toggles every clk (clk/2), tick[1] constantly 1.
//    Assert CLEARn low mid-run -> all outputs 0 immediately.
//  6 (CLKDIV_SYNC_EN) ch0 D=5, ch1 D=5 offset by 2 clk; pulse sync_restart -> both clk_out low next edge.
//    Both rise together 5 clk later.

Source files
------------

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider with per-channel enable, tick strobe and shadowed divisor.
// Optional CLKDIV_SYNC_EN adds a sync_restart input that phase-aligns every channel.
module clock_divider_multi #(
    parameter int CH      = 2,
    parameter int W       = 26,
    parameter int DEF_DIV = 12500000,
    localparam int SELW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            CLEARn,
    input  logic [CH-1:0]   en,
    input  logic            cfg_we,
    input  logic [SELW-1:0] cfg_sel,
    input  logic [W-1:0]    cfg_div,
`ifdef CLKDIV_SYNC_EN
    input  logic            sync_restart,
`endif
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick
);

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] RSTDV = W'(DEF_DIV);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [W-1:0] r_cnt;
        logic [W-1:0] r_active;
        logic [W-1:0] r_shadow;
        logic         r_pend;
        logic         r_clk;
        logic         r_tick;

        logic         w_wr;
        logic         w_idle;
        logic         w_tc;
        logic         w_load;
        logic [W-1:0] w_next;

        assign w_wr = cfg_we && (cfg_sel == SELW'(g));

`ifdef CLKDIV_SYNC_EN
        assign w_idle = !en[g] || (r_active == '0) || sync_restart;
`else
        assign w_idle = !en[g] || (r_active == '0);
`endif

        assign w_tc = !w_idle && (r_cnt == (r_active - ONE));

        // The active divisor may only change where a half-period begins, so no runt pulses appear;
        // a write landing on that same edge bypasses the shadow.
        assign w_load = w_idle || w_tc;
        assign w_next = w_wr ? cfg_div : r_shadow;

        always_ff @(posedge clk or negedge CLEARn) begin
            if (!CLEARn) begin
                r_cnt    <= '0;
                r_active <= RSTDV;
                r_shadow <= RSTDV;
                r_pend   <= 1'b0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_shadow <= cfg_div;
                end

                if (w_load) begin
                    if (w_wr || r_pend) begin
                        r_active <= w_next;
                    end
                    r_pend <= 1'b0;
                end else if (w_wr) begin
                    r_pend <= 1'b1;
                end

                if (w_idle) begin
                    r_cnt  <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_tc) begin
                    r_cnt  <= '0;
                    r_clk  <= ~r_clk;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + ONE;
                    r_tick <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected ticks are queued by the stimulus, a monitor pops them.
// A second three-channel instance checks that an out-of-range channel select is ignored.
module tb_clock_divider_multi;

    localparam int CH  = 2;
    localparam int W   = 8;
    localparam int DEF = 5;

    logic          clk = 1'b0;
    logic          CLEARn;
    logic [CH-1:0] en;
    logic          cfg_we;
    logic [0:0]    cfg_sel;
    logic [W-1:0]  cfg_div;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic          syncRestart;

    logic [2:0]    enB;
    logic          weB;
    logic [1:0]    selB;
    logic [W-1:0]  divB;
    logic [2:0]    clkOutB;
    logic [2:0]    tickB;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int base  = 0;

    typedef struct {
        int   ch;
        int   cyc;
        logic val;
    } expT;

    expT expQ[$];

    clock_divider_multi #(.CH(CH), .W(W), .DEF_DIV(DEF)) dut (
        .clk          (clk),
        .CLEARn       (CLEARn),
        .en           (en),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_div      (cfg_div),
`ifdef CLKDIV_SYNC_EN
        .sync_restart (syncRestart),
`endif
        .clk_out      (clk_out),
        .tick         (tick)
    );

    clock_divider_multi #(.CH(3), .W(W), .DEF_DIV(DEF)) dutB (
        .clk          (clk),
        .CLEARn       (CLEARn),
        .en           (enB),
        .cfg_we       (weB),
        .cfg_sel      (selB),
        .cfg_div      (divB),
`ifdef CLKDIV_SYNC_EN
        .sync_restart (syncRestart),
`endif
        .clk_out      (clkOutB),
        .tick         (tickB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each tick pops the oldest expectation for its channel and checks cycle and clk_out level.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (tick[c]) begin
                int idx;
                idx = -1;
                foreach (expQ[k]) begin
                    if (idx < 0 && expQ[k].ch == c) idx = k;
                end
                tests++;
                if (idx < 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_tick ch%0d: got tick at cycle %0d, expected none", c, cyc);
                end else begin
                    if (expQ[idx].cyc != cyc || expQ[idx].val !== clk_out[c]) begin
                        fails++;
                        $display("[TB] FAIL tick ch%0d: got cycle %0d clk_out %0b, expected cycle %0d clk_out %0b",
                                 c, cyc, clk_out[c], expQ[idx].cyc, expQ[idx].val);
                    end
                    expQ.delete(idx);
                end
            end
        end
    end

    task automatic stepTo(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int ch, input int rel, input logic val);
        expQ.push_back('{ch, base + rel, val});
    endtask

    task automatic applyStimulus(input logic [0:0] sel, input logic [W-1:0] div);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_div = div;
        @(posedge clk);
        #2;
        cfg_we  = 1'b0;
    endtask

    // Hand-computed tick schedule, cycles relative to reset release.
    int   exp0Cyc[11] = '{5, 10, 15, 20, 25, 30, 35, 37, 39, 49, 54};
    logic exp0Val[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
    int   exp1Cyc[21] = '{5, 10, 15, 20, 25, 28, 31, 34, 37, 40, 43, 46, 49, 52, 55, 58, 61, 62, 63, 64, 65};

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got no finish by 20000 ns, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        CLEARn      = 1'b0;
        en          = 2'b11;
        cfg_we      = 1'b0;
        cfg_sel     = '0;
        cfg_div     = '0;
        syncRestart = 1'b0;
        enB         = 3'b111;
        weB         = 1'b0;
        selB        = '0;
        divB        = '0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_clk_out", 32'(clk_out), 32'd0);
        checkOutput("reset_tick", 32'(tick), 32'd0);
        checkOutput("reset_clk_out_B", 32'(clkOutB), 32'd0);

        base   = cyc;
        CLEARn = 1'b1;
        for (int i = 0; i < 11; i++) pushExp(0, exp0Cyc[i], exp0Val[i]);
        for (int i = 0; i < 21; i++) pushExp(1, exp1Cyc[i], (i % 2) == 0);

        // Out-of-range select on the three-channel instance must leave every channel at D=5.
        stepTo(base + 2);
        weB  = 1'b1;
        selB = 2'd3;
        divB = 8'd1;
        stepTo(base + 3);
        weB  = 1'b0;
        stepTo(base + 5);
        @(negedge clk);
        checkOutput("selB_rise_clk", 32'(clkOutB), 32'h7);
        checkOutput("selB_rise_tick", 32'(tickB), 32'h7);
        stepTo(base + 6);
        @(negedge clk);
        checkOutput("selB_no_tick", 32'(tickB), 32'h0);
        stepTo(base + 10);
        @(negedge clk);
        checkOutput("selB_fall_clk", 32'(clkOutB), 32'h0);
        checkOutput("selB_fall_tick", 32'(tickB), 32'h7);

        // ch1 D=3 mid-half-period, ch0 D=2 exactly on its terminal count.
        stepTo(base + 22);
        applyStimulus(1'b1, 8'd3);
        stepTo(base + 34);
        applyStimulus(1'b0, 8'd2);

        // ch0 disabled for four edges, reprogrammed to 5 while idle, then re-enabled.
        stepTo(base + 40);
        en[0] = 1'b0;
        stepTo(base + 41);
        @(negedge clk);
        checkOutput("en_low_clk_41", 32'(clk_out[0]), 32'd0);
        checkOutput("en_low_tick_41", 32'(tick[0]), 32'd0);
        applyStimulus(1'b0, 8'd5);
        for (int t = 42; t <= 44; t++) begin
            stepTo(base + t);
            @(negedge clk);
            checkOutput($sformatf("en_low_clk_%0d", t), 32'(clk_out[0]), 32'd0);
            checkOutput($sformatf("en_low_tick_%0d", t), 32'(tick[0]), 32'd0);
        end
        en[0] = 1'b1;

        // D=0 on ch0 takes effect at the next terminal count and then holds the output low.
        stepTo(base + 49);
        applyStimulus(1'b0, 8'd0);
        for (int t = 55; t <= 58; t++) begin
            stepTo(base + t);
            @(negedge clk);
            checkOutput($sformatf("div0_clk_%0d", t), 32'(clk_out[0]), 32'd0);
        end

        // ch1 D=1: clk/2 with a permanently high tick.
        applyStimulus(1'b1, 8'd1);
        for (int t = 62; t <= 65; t++) begin
            stepTo(base + t);
            @(negedge clk);
            checkOutput($sformatf("div1_tick_%0d", t), 32'(tick[1]), 32'd1);
        end

        #1;
        CLEARn = 1'b0;
        #1;
        checkOutput("async_reset_clk_out", 32'(clk_out), 32'd0);
        checkOutput("async_reset_tick", 32'(tick), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_hold_clk_out", 32'(clk_out), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

`ifdef CLKDIV_SYNC_EN
        // Channels offset by two cycles, then realigned by a one-cycle sync_restart.
        en     = 2'b01;
        base   = cyc;
        CLEARn = 1'b1;
        pushExp(0, 5, 1'b1);
        pushExp(0, 10, 1'b0);
        pushExp(0, 18, 1'b1);
        pushExp(1, 7, 1'b1);
        pushExp(1, 12, 1'b0);
        pushExp(1, 18, 1'b1);
        stepTo(base + 2);
        en = 2'b11;
        stepTo(base + 12);
        syncRestart = 1'b1;
        stepTo(base + 13);
        syncRestart = 1'b0;
        @(negedge clk);
        checkOutput("sync_low", 32'(clk_out), 32'd0);
        stepTo(base + 18);
        @(negedge clk);
        #1;
        checkOutput("sync_aligned", 32'(clk_out), 32'h3);
        checkOutput("sync_queue_drained", 32'(expQ.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
